count_pwm_gen: RTL
==================

# count_pwm_gen

Downstream consumer of the 3-bit free-running synchronous counter. Samples the counter's `count` bus every clock and produces a registered PWM waveform with an 8-cycle period. Duty updates arrive over a valid/ready handshake and take effect only at a period boundary, so the waveform never glitches. The block also checks that `count` increments by exactly 1 mod 8 each cycle, flags any violation, and counts completed periods.

## Interface
- `DUTY_W`, 4: duty input width; legal duty values are 0..8.
- `PER_W`, 8: width of the completed-period counter.

- `clk`, in, 1: single clock; all state is updated on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `count`, in, 3: counter value from the upstream 3-bit synchronous counter.
- `duty_valid`, in, 1: new duty value offered.
- `duty`, in, DUTY_W: requested high-time in cycles per period.
  - Values above 8 are clamped to 8.
- `duty_ready`, out, 1: block can accept a duty value.
  - Combinational: `~pending`.
- `err_clr`, in, 1: clears `seq_err`.
- `pwm_out`, out, 1: registered PWM output.
- `period_start`, out, 1: one-cycle pulse aligned with the first PWM cycle of a period.
- `seq_err`, out, 1: sticky flag for a count-sequence violation.
- `periods`, out, PER_W: completed-period counter; wraps modulo 2^PER_W.

## Operation
- **Internal state:**
  - `active_duty[3:0]`
  - `shadow_duty[3:0]`
  - `pending`
  - `prev_count[2:0]`
  - `prev_valid`
- **Reset values:** all state and all registered outputs are 0. `duty_ready` reads 1 during and after reset.
- **Handshake:**
  - A transfer occurs on a rising edge where `duty_valid && duty_ready`.
  - On transfer: `shadow_duty <= min(duty, 8)` and `pending <= 1`.
  - While `pending` is 1, `duty_ready` is 0. `duty_valid` may be held; no transfer occurs until ready returns.
- **Duty commit:**
  - On any edge where `count == 7` and `pending` is 1: `active_duty <= shadow_duty` and `pending <= 0`.
  - The new duty governs the period whose `count == 0` is sampled on the next edge.
  - A transfer and a commit never coincide, because a transfer requires `pending == 0`.
- **PWM:** each edge, `pwm_out <= (count < active_duty)`. The comparison is 4-bit unsigned, with `count` zero-extended.
  - Duty 0 keeps the output constantly low.
  - Duty 8 keeps the output constantly high.
- **Period start:** each edge, `period_start <= (count == 0)`.
- **Sequence check:**
  - Each edge: `prev_count <= count` and `prev_valid <= 1`.
  - Error condition: `prev_valid` is 1 and `count != prev_count + 1` (3-bit wrap, so 7 is followed by 0).
  - On error, `seq_err <= 1`.
  - `err_clr` clears `seq_err` on the edge. If an error and `err_clr` occur on the same edge, set wins.
  - The first sample after reset is never checked.
- **Period counter:** `periods` increments on an edge where `count == 7` and no error is detected on that same edge.
- **Mid-operation reset:** reset asynchronously clears everything, including `pending`. A pending duty value is discarded. The output returns to duty 0 until a new transfer is made and committed.

## Timing
- **PWM latency:** 1 clock from `count` sample to `pwm_out` / `period_start`.
- **Duty latency:** a value accepted at edge E becomes visible at `pwm_out` on the edge after the first subsequent sample of `count == 0`.
  - Worst case: 9 edges.
  - If the transfer edge itself samples `count == 7`, no commit happens on that edge, because the commit condition uses the pre-edge `pending`. The commit waits for the next `count == 7`.
- **`duty_ready` latency:** returns to 1 on the edge that commits the duty.
- **`seq_err`:** asserts 1 clock after the offending `count` is present. It stays high until an `err_clr` edge that has no concurrent error.
- **Reset release:** the first rising edge after `reset` falls performs normal sampling.

## Test plan
- **Reset, then duty 3:**
  - Stimulus: assert `reset`, free-run `count` 0..7, send duty 3 once `duty_ready` is high.
  - Required: `pwm_out` pattern 1,1,1,0,0,0,0,0 per period starting on the first full period after the commit.
  - Required: `period_start` high on the first 1 of each period.
- **Mid-period update:**
  - Stimulus: with duty 3 active, send duty 6 while `count == 2`.
  - Required: `duty_ready` low until the `count == 7` edge.
  - Required: the current period keeps 3 high cycles; the next period has 6 high cycles.
- **Clamp and extremes:**
  - Stimulus: duty 12.
  - Required: output constantly 1 (clamped to 8).
  - Stimulus: duty 0.
  - Required: output constantly 0; `period_start` still pulses every 8 cycles.
- **Sequence error:**
  - Stimulus: force `count` 0,1,2,5,6.
  - Required: `seq_err` goes to 1 one clock after the 5 is sampled and stays 1.
  - Stimulus: `err_clr` pulsed with no error.
  - Required: `seq_err` clears.
  - Stimulus: `err_clr` on the same edge as a new error.
  - Required: `seq_err` stays 1.
- **Period counter wrap:**
  - Stimulus: run 256 clean periods.
  - Required: `periods` reads 255, then 0.
  - Stimulus: a skipped 7 (6 followed by 0).
  - Required: `periods` does not increment for that period.
- **Asynchronous reset mid-operation:**
  - Stimulus: send duty 5, then assert `reset` between edges while `pending` is 1.
  - Required: all outputs go to 0 immediately; `duty_ready` goes to 1.
  - Required: after release, `pwm_out` stays 0 until a new duty is committed.

Source files
------------

// File: rtl/count_pwm_gen_if.sv
// Bus between the PWM generator and its environment: counter sample, duty handshake,
// error clear and the generated waveform/status outputs.
interface count_pwm_gen_if #(
    parameter int unsigned DUTY_W = 4,
    parameter int unsigned PER_W  = 8
) ();
    logic [2:0]        count;
    logic              duty_valid;
    logic [DUTY_W-1:0] duty;
    logic              duty_ready;
    logic              err_clr;
    logic              pwm_out;
    logic              period_start;
    logic              seq_err;
    logic [PER_W-1:0]  periods;

    modport master (
        output count, duty_valid, duty, err_clr,
        input  duty_ready, pwm_out, period_start, seq_err, periods
    );

    modport slave (
        input  count, duty_valid, duty, err_clr,
        output duty_ready, pwm_out, period_start, seq_err, periods
    );
endinterface

// File: rtl/count_pwm_gen.sv
// 8-cycle PWM generator driven by an external 3-bit counter, with glitch-free duty updates,
// a count-sequence checker and a completed-period counter.
module count_pwm_gen #(
    parameter int unsigned DUTY_W = 4,
    parameter int unsigned PER_W  = 8
) (
    input logic              clk,
    input logic              reset,
    count_pwm_gen_if.slave   bus
);
    localparam logic [DUTY_W-1:0] DutyMax = DUTY_W'(8);

    logic [3:0]       active_duty_q, active_duty_d;
    logic [3:0]       shadow_duty_q, shadow_duty_d;
    logic             pending_q, pending_d;
    logic [2:0]       prev_count_q, prev_count_d;
    logic             prev_valid_q, prev_valid_d;
    logic             pwm_q, pwm_d;
    logic             period_start_q, period_start_d;
    logic             seq_err_q, seq_err_d;
    logic [PER_W-1:0] periods_q, periods_d;

    logic       transfer;
    logic       commit;
    logic       seq_bad;
    logic [3:0] duty_clamped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_duty_q  <= '0;
            shadow_duty_q  <= '0;
            pending_q      <= 1'b0;
            prev_count_q   <= '0;
            prev_valid_q   <= 1'b0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            seq_err_q      <= 1'b0;
            periods_q      <= '0;
        end else begin
            active_duty_q  <= active_duty_d;
            shadow_duty_q  <= shadow_duty_d;
            pending_q      <= pending_d;
            prev_count_q   <= prev_count_d;
            prev_valid_q   <= prev_valid_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            seq_err_q      <= seq_err_d;
            periods_q      <= periods_d;
        end
    end

    always_comb begin
        duty_clamped   = (bus.duty > DutyMax) ? 4'd8 : 4'(bus.duty);
        transfer       = bus.duty_valid && !pending_q;
        commit         = (bus.count == 3'd7) && pending_q;
        seq_bad        = prev_valid_q && (bus.count != 3'(prev_count_q + 3'd1));

        active_duty_d  = active_duty_q;
        shadow_duty_d  = shadow_duty_q;
        pending_d      = pending_q;
        seq_err_d      = seq_err_q;
        periods_d      = periods_q;

        // Transfer needs pending low and commit needs it high, so they are exclusive.
        if (transfer) begin
            shadow_duty_d = duty_clamped;
            pending_d     = 1'b1;
        end
        if (commit) begin
            active_duty_d = shadow_duty_q;
            pending_d     = 1'b0;
        end

        pwm_d          = ({1'b0, bus.count} < active_duty_q);
        period_start_d = (bus.count == 3'd0);
        prev_count_d   = bus.count;
        prev_valid_d   = 1'b1;

        // A fresh error outranks a concurrent clear.
        if (seq_bad) begin
            seq_err_d = 1'b1;
        end else if (bus.err_clr) begin
            seq_err_d = 1'b0;
        end

        if ((bus.count == 3'd7) && !seq_bad) begin
            periods_d = periods_q + PER_W'(1);
        end
    end

    assign bus.duty_ready   = ~pending_q;
    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = period_start_q;
    assign bus.seq_err      = seq_err_q;
    assign bus.periods      = periods_q;
endmodule
